// File: rtl/life_pkg.sv
// life_pkg: shared grid geometry, scheduler state encoding and row one-hot helper
package life_pkg;
    localparam int GRID_ROWS = 8;
    localparam int GRID_COLS = 8;
    localparam int ROW_W     = $clog2(GRID_ROWS);
    localparam int GRID_W    = GRID_ROWS * GRID_COLS;

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    function automatic logic [GRID_ROWS-1:0] row_onehot(input logic [ROW_W-1:0] idx);
        return GRID_ROWS'(1) << idx;
    endfunction
endpackage

// File: rtl/life_row_scan.sv
// life_row_scan: prescaled row multiplexer driving one-hot rows and registered row data
module life_row_scan
    import life_pkg::*;
#(
    parameter int SCAN_DIV = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [GRID_W-1:0]    frame_buf_i,
    output logic [GRID_ROWS-1:0] row_o,
    output logic [GRID_COLS-1:0] data_o,
    output logic                 frame_boundary_o,
    output logic                 frame_start_o
);
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0]        presc_q, presc_d;
    logic [ROW_W-1:0]     idx_q, idx_d;
    logic [GRID_ROWS-1:0] row_d;
    logic [GRID_COLS-1:0] data_d;
    logic                 tick;

    // advance the row on each prescaler wrap; data comes from the buffer value being committed this cycle
    always_comb begin
        tick             = presc_q == PW'(SCAN_DIV - 1);
        presc_d          = tick ? '0 : presc_q + 1'b1;
        idx_d            = tick ? idx_q + 1'b1 : idx_q;
        row_d            = tick ? row_onehot(idx_d) : row_o;
        data_d           = tick ? frame_buf_i[idx_d*GRID_COLS +: GRID_COLS] : data_o;
        frame_boundary_o = tick && idx_q == ROW_W'(GRID_ROWS - 1);
    end

    // scan registers; row 0 is active out of reset with blank data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            idx_q         <= '0;
            row_o         <= GRID_ROWS'(1);
            data_o        <= '0;
            frame_start_o <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            row_o         <= row_d;
            data_o        <= data_d;
            frame_start_o <= frame_boundary_o;
        end
    end
endmodule

// File: rtl/life_scan_sched.sv
// life_scan_sched: LED scan controller with tear-free grid shadowing and generation request scheduling
module life_scan_sched
    import life_pkg::*;
#(
    parameter int SCAN_DIV   = 64,
    parameter int GEN_FRAMES = 32
) (
    input  logic                 clk,
    input  logic                 _rst,
    input  logic                 run,
    input  logic                 step,
    input  logic [GRID_W-1:0]    grid_in,
    input  logic                 gen_ack,
    output logic                 gen_req,
    output logic [GRID_ROWS-1:0] row,
    output logic [GRID_COLS-1:0] data,
    output logic                 frame_start,
    output logic                 busy
);
    localparam int FW = $clog2(GEN_FRAMES) + 1;

    state_t            state_q, state_d;
    logic [FW-1:0]     fc_q, fc_d;
    logic [GRID_W-1:0] fb_q, fb_d;
    logic              boundary, idle, go;

    life_row_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk             (clk),
        .rst_n           (_rst),
        .frame_buf_i     (fb_d),
        .row_o           (row),
        .data_o          (data),
        .frame_boundary_o(boundary),
        .frame_start_o   (frame_start)
    );

    // request on a step or on the last frame of an auto-run period; ack only counts once in REQ
    always_comb begin
        idle    = state_q == ST_IDLE;
        go      = step || (run && boundary && fc_q == FW'(GEN_FRAMES - 1));
        state_d = idle ? (go ? ST_REQ : ST_IDLE) : (gen_ack ? ST_IDLE : ST_REQ);
    end

    // shadow latch only at idle frame boundaries; frame counter paces auto-run
    always_comb begin
        fb_d = (boundary && idle) ? grid_in : fb_q;
        fc_d = !idle ? fc_q : go ? '0 : (boundary && run) ? fc_q + 1'b1 : fc_q;
    end

    // handshake outputs follow the state directly
    always_comb begin
        gen_req = state_q == ST_REQ;
        busy    = state_q == ST_REQ;
    end

    // scheduler state register
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // frame counter and shadow buffer registers
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            fc_q <= '0;
            fb_q <= '0;
        end else begin
            fc_q <= fc_d;
            fb_q <= fb_d;
        end
    end
endmodule

// File: tb/tb_life_scan_sched.sv
// tb_life_scan_sched: directed scenarios with a cycle-count based reference model
module tb_life_scan_sched;
    localparam int SD = 4;
    localparam int GF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [63:0] grid = '0;
    logic        gen_ack;
    logic        gen_req, frame_start, busy;
    logic [7:0]  row, data;
    logic        auto_ack = 1'b0;
    logic        man_ack = 1'b0;

    int passed = 0;
    int total = 0;

    int          t;
    logic [63:0] mfb;
    logic [7:0]  mshown;
    bit          mreq, tk, bnd, go;
    int          mfc;
    int          r1, r2, r3, hi;

    life_scan_sched #(.SCAN_DIV(SD), .GEN_FRAMES(GF)) dut (
        .clk        (clk),
        ._rst       (rst_n),
        .run        (run),
        .step       (step),
        .grid_in    (grid),
        .gen_ack    (gen_ack),
        .gen_req    (gen_req),
        .row        (row),
        .data       (data),
        .frame_start(frame_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h (t=%0d)", nm, act, exp, t);
    endtask

    // matrix responder: one-cycle ack for each request in auto mode
    always @(negedge clk) gen_ack = auto_ack ? (gen_req && !gen_ack) : man_ack;

    // reference model: row position derives from cycles since reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; mfb = '0; mshown = '0; mreq = 0; mfc = 0;
        end else begin
            tk  = (t % SD) == SD - 1;
            bnd = tk && ((t / SD) % 8) == 7;
            if (!mreq) begin
                go = step || (run && bnd && mfc == GF - 1);
                if (bnd) mfb = grid;
                if (go) mfc = 0;
                else if (bnd && run) mfc++;
                mreq = go;
            end else if (gen_ack) mreq = 0;
            t++;
            if (tk) mshown = mfb[((t / SD) % 8) * 8 +: 8];
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("m_row", 64'(row), 64'(8'h01 << ((t / SD) % 8)));
            check("m_data", 64'(data), 64'(mshown));
            check("m_req", 64'(gen_req), 64'(mreq));
            check("m_busy", 64'(busy), 64'(mreq));
            check("m_fs", 64'(frame_start), 64'(t > 0 && t % (8 * SD) == 0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input logic lvl, input string nm);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gen_req === lvl) return;
        end
        total++;
        $display("FAIL %s: timeout waiting gen_req=%b", nm, lvl);
    endtask

    task automatic wait_fs(input string nm);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) return;
        end
        total++;
        $display("FAIL %s: timeout waiting frame_start", nm);
    endtask

    initial begin
        grid = '0;
        grid[7:0] = 8'hA5;
        grid[63:56] = 8'h3C;
        cyc(3);
        check("rst_row", 64'(row), 64'h01);
        check("rst_data", 64'(data), 64'h00);
        check("rst_req", 64'(gen_req), 64'h0);
        check("rst_fs", 64'(frame_start), 64'h0);
        #2 rst_n = 1'b1;
        cyc(3);
        check("row_t3", 64'(row), 64'h01);
        cyc(1);
        check("row_t4", 64'(row), 64'h02);
        check("data_t4", 64'(data), 64'h00);
        cyc(24);
        check("row7_f0", 64'(row), 64'h80);
        check("data7_f0", 64'(data), 64'h00);
        cyc(4);
        check("row_t32", 64'(row), 64'h01);
        check("fs_t32", 64'(frame_start), 64'h1);
        check("latch_r0", 64'(data), 64'hA5);
        cyc(1);
        check("fs_t33", 64'(frame_start), 64'h0);
        cyc(27);
        check("latch_r7_row", 64'(row), 64'h80);
        check("latch_r7", 64'(data), 64'h3C);
        step = 1'b1;
        hi = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (gen_req) hi++;
            step = (i == 2);
            man_ack = (i == 4);
        end
        @(negedge clk);
        man_ack = 1'b0;
        check("step_hi_cycles", 64'(hi), 64'd4);
        check("step_req_drop", 64'(gen_req), 64'h0);
        cyc(10);
        check("step_no_requeue", 64'(gen_req), 64'h0);
        check("step_busy_low", 64'(busy), 64'h0);
        auto_ack = 1'b1;
        run = 1'b1;
        wait_req(1'b1, "run_r1");
        r1 = t;
        check("run_r1_row", 64'(row), 64'h01);
        check("run_r1_t", 64'(r1), 64'd128);
        wait_req(1'b0, "run_f1");
        wait_req(1'b1, "run_r2");
        r2 = t;
        check("run_r2_row", 64'(row), 64'h01);
        wait_req(1'b0, "run_f2");
        wait_req(1'b1, "run_r3");
        r3 = t;
        check("run_period1", 64'(r2 - r1), 64'd64);
        check("run_period2", 64'(r3 - r2), 64'd64);
        wait_req(1'b0, "run_f3");
        run = 1'b0;
        auto_ack = 1'b0;
        wait_fs("tear_sync");
        step = 1'b1;
        grid = {64{1'b1}};
        @(negedge clk);
        step = 1'b0;
        check("tear_req", 64'(gen_req), 64'h1);
        wait_fs("tear_b1");
        check("tear_old_r0", 64'(data), 64'hA5);
        cyc(28);
        check("tear_old_r7_row", 64'(row), 64'h80);
        check("tear_old_r7", 64'(data), 64'h3C);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        check("tear_ack_drop", 64'(gen_req), 64'h0);
        wait_fs("tear_b2");
        check("tear_new_r0", 64'(data), 64'hFF);
        cyc(28);
        check("tear_new_r7", 64'(data), 64'hFF);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("arst_pre_req", 64'(gen_req), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", 64'(gen_req), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_row", 64'(row), 64'h01);
        check("arst_data", 64'(data), 64'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc(4);
        check("arst_row_t4", 64'(row), 64'h02);
        check("arst_buf_clear", 64'(data), 64'h00);
        cyc(40);
        check("arst_relatch", 64'(data), 64'hFF);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
